// File: rtl/sm_arb_pkg.sv
// Shared definitions for the data-memory bus arbiter: state encoding,
// owner-index width and the default burst limit.
package sm_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    localparam int unsigned OWNER_W       = 2;
    localparam int unsigned MAX_BURST_DEF = 8;

endpackage

// File: rtl/sm_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_start
// (wrapping modulo N) that is not excluded.
module sm_rr_pick
    import sm_arb_pkg::*;
#(
    parameter int unsigned N = 2
)(
    input  logic [N-1:0]       i_req,
    input  logic [OWNER_W-1:0] i_start,
    input  logic [N-1:0]       i_excl,
    output logic [N-1:0]       o_gnt,
    output logic [OWNER_W-1:0] o_idx,
    output logic               o_valid
);

    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Scan candidates in rotating order, keeping the first hit
    always_comb begin
        int unsigned j;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(i_start) + k) % N;
            if (!o_valid && w_cand[SEL_W'(j)]) begin
                o_gnt[SEL_W'(j)] = 1'b1;
                o_idx            = OWNER_W'(j);
                o_valid          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory bus between up to four masters.
// Registered grant, single-cycle transfers, optional locked bursts.
// Build option: SM_ARB_BURST_LIMIT_EN caps a locked burst at MAX_BURST transfers.
module sm_bus_arbiter
    import sm_arb_pkg::*;
#(
    parameter int unsigned MASTERS   = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MASTERS-1:0]    m_req,
    input  logic [MASTERS-1:0]    m_lock,
    input  logic [MASTERS-1:0]    m_we,
    input  logic [MASTERS*AW-1:0] m_addr,
    input  logic [MASTERS*DW-1:0] m_wdata,
    output logic [MASTERS-1:0]    m_gnt,
    output logic [DW-1:0]         m_rdata,
    output logic [AW-1:0]         s_addr,
    output logic                  s_we,
    output logic [DW-1:0]         s_wdata,
    input  logic [DW-1:0]         s_rdata,
    output logic [OWNER_W-1:0]    owner
);

    localparam logic [OWNER_W-1:0] LAST_RST = OWNER_W'(MASTERS - 1);

    // Reject unsupported configurations at elaboration
    if (MASTERS < 2 || MASTERS > 4 || MAX_BURST < 1) begin : g_bad_cfg
        $error("sm_bus_arbiter: MASTERS must be 2..4 and MAX_BURST >= 1");
    end

    arb_state_e         r_state, w_state_nx;
    logic [MASTERS-1:0] r_gnt, w_gnt_nx;
    logic [OWNER_W-1:0] r_owner, w_owner_nx;
    logic [OWNER_W-1:0] r_last, w_last_nx;
    logic [OWNER_W-1:0] w_start;
    logic [MASTERS-1:0] w_xfer_vec;
    logic               w_xfer;
    logic               w_hold;
    logic               w_limit;
    logic [MASTERS-1:0] w_pick_gnt;
    logic [OWNER_W-1:0] w_pick_idx;
    logic               w_pick_valid;

    assign w_start    = (r_last == LAST_RST) ? '0 : r_last + OWNER_W'(1);
    assign w_xfer_vec = r_gnt & m_req;
    assign w_xfer     = |w_xfer_vec;
    assign w_hold     = |(w_xfer_vec & m_lock);

`ifdef SM_ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    assign w_limit = w_hold && (r_cnt == CNT_W'(MAX_BURST - 1));

    // Locked-burst transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nx;
        end
    end
`else
    assign w_limit = 1'b0;
`endif

    // Next requester after the round-robin pointer, skipping the current owner
    sm_rr_pick #(
        .N (MASTERS)
    ) u_pick (
        .i_req   (m_req),
        .i_start (w_start),
        .i_excl  (r_gnt),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Arbiter state, grant, owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
        end
    end

    // Next-state: keep a locking owner, otherwise hand over round-robin
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
`ifdef SM_ARB_BURST_LIMIT_EN
        w_cnt_nx   = r_cnt;
`endif
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nx = ARB_GRANT;
                    w_gnt_nx   = w_pick_gnt;
                    w_owner_nx = w_pick_idx;
                    w_last_nx  = w_pick_idx;
                end
            end
            ARB_GRANT, ARB_LOCKED: begin
                if (w_hold && !w_limit) begin
                    w_state_nx = ARB_LOCKED;
`ifdef SM_ARB_BURST_LIMIT_EN
                    w_cnt_nx   = r_cnt + CNT_W'(1);
`endif
                end else if (w_pick_valid) begin
                    w_state_nx = ARB_GRANT;
                    w_gnt_nx   = w_pick_gnt;
                    w_owner_nx = w_pick_idx;
                    w_last_nx  = w_pick_idx;
`ifdef SM_ARB_BURST_LIMIT_EN
                    w_cnt_nx   = '0;
`endif
                end else if (w_limit) begin
                    // Burst capped but nobody else waiting: restart the same owner
                    w_state_nx = ARB_GRANT;
`ifdef SM_ARB_BURST_LIMIT_EN
                    w_cnt_nx   = '0;
`endif
                end else begin
                    w_state_nx = ARB_IDLE;
                    w_gnt_nx   = '0;
`ifdef SM_ARB_BURST_LIMIT_EN
                    w_cnt_nx   = '0;
`endif
                end
            end
            default: begin
                w_state_nx = ARB_IDLE;
                w_gnt_nx   = '0;
`ifdef SM_ARB_BURST_LIMIT_EN
                w_cnt_nx   = '0;
`endif
            end
        endcase
    end

    // Route the transferring owner's fields to the matrix; zeros otherwise
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_we    = 1'b0;
        if (w_xfer) begin
            s_addr  = AW'(m_addr >> (32'(r_owner) * AW));
            s_wdata = DW'(m_wdata >> (32'(r_owner) * DW));
            s_we    = |(w_xfer_vec & m_we);
        end
    end

    assign m_gnt   = r_gnt;
    assign owner   = r_owner;
    assign m_rdata = s_rdata;

endmodule
